// File: rtl/mem_display_if.sv
// Request, RAM and display signals shared by mem_display_ctrl and its neighbours.
// master = front end / RAM side, slave = the sequencer.
interface mem_display_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) ();
   logic              inc_pulse;
   logic              dec_pulse;
   logic              wr_pulse;
   logic [DATA_W-1:0] sw_data;
   logic [DATA_W-1:0] mem_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [ADDR_W-1:0] disp_addr;
   logic [DATA_W-1:0] disp_data;
   logic              busy;

   modport master (
      output inc_pulse, dec_pulse, wr_pulse, sw_data, mem_rdata,
      input  mem_addr, mem_we, mem_wdata, disp_addr, disp_data, busy
   );

   modport slave (
      input  inc_pulse, dec_pulse, wr_pulse, sw_data, mem_rdata,
      output mem_addr, mem_we, mem_wdata, disp_addr, disp_data, busy
   );
endinterface

// File: rtl/mem_display_ctrl.sv
// Address/data sequencer between the one-shot front end and a single-port sync RAM.
// Steps, writes and periodic re-reads of the current location for the 7-seg display.
module mem_display_ctrl #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 16,
   parameter int REFRESH_CYC = 1000000
) (
   input  logic         clk,
   input  logic         reset,
   mem_display_if.slave bus
);
   localparam int CNT_W = (REFRESH_CYC > 0) ? $clog2(REFRESH_CYC + 1) : 1;
   localparam bit REFRESH_EN = (REFRESH_CYC != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = REFRESH_EN ? CNT_W'(REFRESH_CYC - 1) : '0;

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_WRITE,
      S_READ,
      S_CAPTURE
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_disp_data;
   logic              r_we;
   logic              r_busy;
   logic [CNT_W-1:0]  r_cnt;
   logic              w_do_wr;
   logic              w_do_inc;
   logic              w_do_dec;
   logic              w_refresh;

   assign w_refresh = REFRESH_EN && (r_cnt == CNT_LAST);

   always_comb begin
      w_next   = r_state;
      w_do_wr  = 1'b0;
      w_do_inc = 1'b0;
      w_do_dec = 1'b0;
      unique case (r_state)
         S_INIT:    w_next = S_READ;
         S_IDLE: begin
            if (bus.wr_pulse) begin
               w_do_wr = 1'b1;
               w_next  = S_WRITE;
            end else if (bus.inc_pulse && !bus.dec_pulse) begin
               w_do_inc = 1'b1;
               w_next   = S_READ;
            end else if (bus.dec_pulse && !bus.inc_pulse) begin
               w_do_dec = 1'b1;
               w_next   = S_READ;
            end else if (!bus.inc_pulse && !bus.dec_pulse && w_refresh) begin
               w_next = S_READ;
            end
         end
         S_WRITE:   w_next = S_READ;
         S_READ:    w_next = S_CAPTURE;
         S_CAPTURE: w_next = S_IDLE;
         default:   w_next = S_INIT;
      endcase
   end

   // mem_we and busy are registered from the next state so they are glitch-free
   // and still drop straight to their reset values on an async reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_INIT;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_disp_data <= '0;
         r_we        <= 1'b0;
         r_busy      <= 1'b1;
         r_cnt       <= '0;
      end else begin
         r_state <= w_next;
         r_we    <= (w_next == S_WRITE);
         r_busy  <= (w_next != S_IDLE);
         if (w_do_wr) r_wdata <= bus.sw_data;
         if (w_do_inc)      r_addr <= r_addr + ADDR_W'(1);
         else if (w_do_dec) r_addr <= r_addr - ADDR_W'(1);
         if (r_state == S_CAPTURE) r_disp_data <= bus.mem_rdata;
         if (REFRESH_EN && r_state == S_IDLE && w_next == S_IDLE) r_cnt <= r_cnt + CNT_W'(1);
         else                                                     r_cnt <= '0;
      end
   end

   assign bus.mem_addr  = r_addr;
   assign bus.disp_addr = r_addr;
   assign bus.mem_we    = r_we;
   assign bus.mem_wdata = r_wdata;
   assign bus.disp_data = r_disp_data;
   assign bus.busy      = r_busy;
endmodule

// File: tb/tb_mem_display_ctrl.sv
// Scoreboard bench for mem_display_ctrl: directed requests push expected completions
// and writes; a monitor pops them when busy falls or mem_we is seen.
module tb_mem_display_ctrl;
   typedef struct {
      logic [7:0]  addr;
      logic [15:0] data;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_a = 1'b1;
   logic        rst_b = 1'b1;
   logic        ram_fill = 1'b1;
   logic        bd_a = 1'b0;
   logic        bd_b = 1'b0;
   logic [7:0]  bd_addr = '0;
   logic [15:0] bd_data = '0;
   logic [15:0] ram_a [256];
   logic [15:0] ram_b [256];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   exp_t        sbq[$];
   exp_t        wq[$];

   mem_display_if #(.ADDR_W(8), .DATA_W(16)) ifa ();
   mem_display_if #(.ADDR_W(8), .DATA_W(16)) ifb ();

   mem_display_ctrl #(.ADDR_W(8), .DATA_W(16), .REFRESH_CYC(10)) u_dut_a (
      .clk(clk), .reset(rst_a), .bus(ifa)
   );
   mem_display_ctrl #(.ADDR_W(8), .DATA_W(16), .REFRESH_CYC(0)) u_dut_b (
      .clk(clk), .reset(rst_b), .bus(ifb)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] ram_init(input logic [7:0] a);
      if (a == 8'h00) return 16'hBEEF;
      return {a ^ 8'h3C, ~a};
   endfunction

   always @(posedge clk) begin
      if (ram_fill) begin
         for (int i = 0; i < 256; i++) begin
            ram_a[i] <= ram_init(8'(i));
            ram_b[i] <= ram_init(8'(i));
         end
      end else begin
         if (bd_a) ram_a[bd_addr] <= bd_data;
         if (ifa.mem_we) ram_a[ifa.mem_addr] <= ifa.mem_wdata;
         if (bd_b) ram_b[bd_addr] <= bd_data;
         if (ifb.mem_we) ram_b[ifb.mem_addr] <= ifb.mem_wdata;
      end
      ifa.mem_rdata <= ram_a[ifa.mem_addr];
      ifb.mem_rdata <= ram_b[ifb.mem_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic monitor();
      logic pb;
      exp_t e;
      pb = 1'b1;
      forever begin
         @(negedge clk);
         if (ifa.mem_we === 1'b1) begin
            if (wq.size() == 0) check("unexpected_write", 32'(ifa.mem_addr), 32'hFFFF_FFFF);
            else begin
               e = wq.pop_front();
               check("wr_addr", 32'(ifa.mem_addr), 32'(e.addr));
               check("wr_data", 32'(ifa.mem_wdata), 32'(e.data));
               check("wr_cycle", 32'(cyc), 32'(e.cyc));
            end
         end
         if (pb && ifa.busy === 1'b0) begin
            if (sbq.size() == 0) check("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
            else begin
               e = sbq.pop_front();
               check("done_addr", 32'(ifa.disp_addr), 32'(e.addr));
               check("done_data", 32'(ifa.disp_data), 32'(e.data));
               check("done_cycle", 32'(cyc), 32'(e.cyc));
            end
         end
         pb = ifa.busy;
      end
   endtask

   // called #1 after an edge; returns #1 after the edge where cyc reaches c
   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input logic inc, input logic dec, input logic wr, input logic [15:0] sw,
                        input logic [7:0] ea, input logic [15:0] ed, input int lat,
                        output int done);
      int n;
      n = cyc + 1;
      ifa.inc_pulse = inc;
      ifa.dec_pulse = dec;
      ifa.wr_pulse  = wr;
      ifa.sw_data   = sw;
      done = n + lat;
      if (lat > 0) sbq.push_back('{ea, ed, done});
      if (wr) wq.push_back('{ea, sw, n});
      @(posedge clk);
      #1;
      ifa.inc_pulse = 1'b0;
      ifa.dec_pulse = 1'b0;
      ifa.wr_pulse  = 1'b0;
   endtask

   initial begin
      int d;
      int c;
      ifa.inc_pulse = 1'b0; ifa.dec_pulse = 1'b0; ifa.wr_pulse = 1'b0; ifa.sw_data = '0;
      ifb.inc_pulse = 1'b0; ifb.dec_pulse = 1'b0; ifb.wr_pulse = 1'b0; ifb.sw_data = '0;
      fork
         monitor();
      join_none
      repeat (2) @(posedge clk);
      #1;
      ram_fill = 1'b0;
      check("rst_busy", 32'(ifa.busy), 32'd1);
      check("rst_addr", 32'(ifa.disp_addr), 32'd0);
      check("rst_data", 32'(ifa.disp_data), 32'd0);
      check("rst_we", 32'(ifa.mem_we), 32'd0);
      check("rst_wdata", 32'(ifa.mem_wdata), 32'd0);

      // power-up read of address 0: busy for INIT, READ, CAPTURE
      c = cyc;
      rst_a = 1'b0;
      rst_b = 1'b0;
      sbq.push_back('{8'h00, 16'hBEEF, c + 3});
      wait_until(c + 3);

      // DUT B has refresh disabled; change its RAM under it and it must not notice
      bd_b = 1'b1; bd_addr = 8'h00; bd_data = 16'hA5A5;
      issue(1'b0, 1'b1, 1'b0, 16'h0, 8'hFF, ram_init(8'hFF), 2, d);
      bd_b = 1'b0;
      check("dec_wrap_addr", 32'(ifa.disp_addr), 32'hFF);
      check("dec_busy", 32'(ifa.busy), 32'd1);
      wait_until(d);

      issue(1'b1, 1'b0, 1'b0, 16'h0, 8'h00, 16'hBEEF, 2, d);
      check("inc_wrap_addr", 32'(ifa.disp_addr), 32'h00);
      wait_until(d);
      issue(1'b0, 1'b1, 1'b0, 16'h0, 8'hFF, ram_init(8'hFF), 2, d);
      check("dec_from0_addr", 32'(ifa.disp_addr), 32'hFF);
      wait_until(d);

      for (int i = 0; i < 6; i++) begin
         issue(1'b1, 1'b0, 1'b0, 16'h0, 8'(i), ram_init(8'(i)), 2, d);
         wait_until(d);
      end

      issue(1'b0, 1'b0, 1'b1, 16'h1234, 8'h05, 16'h1234, 3, d);
      check("wr_busy", 32'(ifa.busy), 32'd1);
      wait_until(d);

      issue(1'b1, 1'b1, 1'b0, 16'h0, 8'h00, 16'h0, 0, d);
      wait_until(d + 2);
      check("incdec_idle", 32'(ifa.busy), 32'd0);
      check("incdec_addr", 32'(ifa.disp_addr), 32'h05);

      issue(1'b1, 1'b0, 1'b1, 16'hCAFE, 8'h05, 16'hCAFE, 3, d);
      check("wrinc_addr", 32'(ifa.disp_addr), 32'h05);
      wait_until(d);

      // second inc lands in READ and must be dropped
      issue(1'b1, 1'b0, 1'b0, 16'h0, 8'h06, ram_init(8'h06), 2, d);
      ifa.inc_pulse = 1'b1;
      @(posedge clk);
      #1;
      ifa.inc_pulse = 1'b0;
      wait_until(d);
      check("drop_addr", 32'(ifa.disp_addr), 32'h06);

      // refresh launches after 10 idle cycles, capture 2 edges later
      bd_a = 1'b1; bd_addr = 8'h06; bd_data = 16'hA5A5;
      sbq.push_back('{8'h06, 16'hA5A5, d + 12});
      @(posedge clk);
      #1;
      bd_a = 1'b0;
      wait_until(d + 12);

      // reset during WRITE: mem_we must drop with no clock edge
      ifa.wr_pulse = 1'b1;
      ifa.sw_data  = 16'h7777;
      @(posedge clk);
      #1;
      ifa.wr_pulse = 1'b0;
      check("abort_we_high", 32'(ifa.mem_we), 32'd1);
      #2;
      rst_a = 1'b1;
      #1;
      check("abort_we_low", 32'(ifa.mem_we), 32'd0);
      check("abort_busy", 32'(ifa.busy), 32'd1);
      check("abort_addr", 32'(ifa.disp_addr), 32'd0);
      check("abort_wdata", 32'(ifa.mem_wdata), 32'd0);
      check("abort_data", 32'(ifa.disp_data), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("abort_ram", 32'(ram_a[6]), 32'hA5A5);
      c = cyc;
      rst_a = 1'b0;
      sbq.push_back('{8'h00, 16'hBEEF, c + 3});
      wait_until(c + 3);

      wait_until(cyc + 3);
      check("norefresh_data", 32'(ifb.disp_data), 32'hBEEF);
      check("norefresh_busy", 32'(ifb.busy), 32'd0);
      check("norefresh_addr", 32'(ifb.disp_addr), 32'd0);
      check("sb_drained", 32'(sbq.size()), 32'd0);
      check("wq_drained", 32'(wq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_display_ctrl.md
# mem_display_ctrl

Sequencer between the user-input front end (debounced one-shot pulses, slide switches) and a single-port synchronous RAM in the memory-display lab. Owns the current address, issues RAM reads and writes, and holds the address/data values that the 8-digit seven-segment path displays (address on the upper digits, data on the lower). Periodically re-reads the current location so the display tracks RAM contents changed by other sources. Sits between the one-shot modules and the digit mux feeding the pixel controller.

## Interface
- ADDR_W, 8, RAM address width; also the width of disp_addr.
- DATA_W, 16, RAM data width; also the width of disp_data and sw_data.
- REFRESH_CYC, 1000000, idle cycles between automatic re-reads; 0 disables refresh.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- inc_pulse  in  1  one-cycle request: address + 1, then read.
- dec_pulse  in  1  one-cycle request: address - 1, then read.
- wr_pulse  in  1  one-cycle request: write sw_data to the current address, then read back.
- sw_data  in  DATA_W  write data, sampled only on the edge that accepts wr_pulse.
- mem_rdata  in  DATA_W  RAM read data; valid the cycle after the address is sampled.
- mem_addr  out  ADDR_W  RAM address (registered; equals disp_addr).
- mem_we  out  1  RAM write enable; high for exactly one cycle per accepted write.
- mem_wdata  out  DATA_W  registered write data.
- disp_addr  out  ADDR_W  current address for display.
- disp_data  out  DATA_W  last captured read data for display.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States: INIT, IDLE, WRITE, READ, CAPTURE.
- INIT: reset state; the next edge moves to READ. This performs the power-up read of address 0.
- IDLE: requests are accepted with priority wr_pulse > inc_pulse/dec_pulse.
  - wr_pulse: mem_wdata <= sw_data; go to WRITE.
  - Only inc_pulse: addr <= addr + 1, modulo 2^ADDR_W; go to READ.
  - Only dec_pulse: addr <= addr - 1, modulo 2^ADDR_W; go to READ.
  - inc_pulse and dec_pulse together, no wr_pulse: ignored; stay in IDLE; refresh counter keeps counting.
  - No request and refresh counter == REFRESH_CYC-1 (REFRESH_CYC != 0): go to READ; addr unchanged.
- WRITE: mem_we = 1 for this one cycle; next state READ.
- READ: RAM samples mem_addr at the end of this cycle; next state CAPTURE.
- CAPTURE: disp_data <= mem_rdata at the end of this cycle; next state IDLE.
- Pulses that arrive while busy = 1 are dropped. They are not queued.
- Refresh counter:
  - Counts only in IDLE.
  - Cleared on every transition out of IDLE and on reset.
  - Width is ceil(log2(REFRESH_CYC+1)), minimum 1.
- Reset is asynchronous and can occur mid-operation. All outputs take reset values immediately:
  - addr = 0, disp_data = 0, mem_wdata = 0, mem_we = 0, busy = 1 (INIT).
  - A write in progress is aborted, with no partial second cycle.
  - State returns to INIT.

## Timing
- Step (inc/dec) accepted at edge n:
  - disp_addr/mem_addr hold the new value after edge n.
  - busy is high after n.
  - disp_data updates at edge n+2; IDLE after n+2.
- Write accepted at edge n:
  - mem_we is high during cycle n..n+1; RAM writes at edge n+1.
  - READ during n+1..n+2.
  - disp_data shows the written value after edge n+3; busy drops at n+3.
- Refresh: the re-read launches at the edge on which the counter would reach REFRESH_CYC, i.e. after exactly REFRESH_CYC consecutive idle cycles. disp_data updates 2 edges later.
- Minimum request spacing: 3 cycles for inc/dec, 4 cycles for writes.
- mem_we never asserts outside WRITE. mem_addr never changes while mem_we = 1.

## Test plan
- Reset release with RAM[0]=16'hBEEF -> busy high 3 edges (INIT, READ, CAPTURE); disp_addr=0, disp_data=16'hBEEF.
- From addr 8'hFF, inc_pulse -> disp_addr=8'h00 at the next edge, disp_data=RAM[0] two edges later. Then dec_pulse from 0 -> disp_addr=8'hFF.
- wr_pulse at addr 8'h05 with sw_data=16'h1234 -> exactly one mem_we cycle with mem_addr=5, mem_wdata=16'h1234; disp_data=16'h1234 three edges after acceptance.
- Simultaneous pulses:
  - inc+dec together -> no state change.
  - wr+inc together -> write performed, address unchanged.
  - inc_pulse while busy -> dropped; disp_addr increments only once.
- REFRESH_CYC=10: backdoor-write RAM[cur] to 16'hA5A5 while idle -> disp_data=16'hA5A5 within 12 cycles. REFRESH_CYC=0 -> disp_data never changes.
- Assert reset during the WRITE cycle -> mem_we falls immediately with no clock; RAM is unchanged; after release the INIT read of address 0 completes normally.
